minimax_sysmem: RTL and testbench
=================================

// Module: minimax_sysmem
// PURPOSE
//  Synthesisable memory and MMIO subsystem for the minimax core; replaces the bench-only RAM/peripheral model.
//  One shared RAM serves a 16-bit instruction port and a 32-bit data port with configurable read latency.
//  Top-of-memory MMIO provides multi-channel console output through a buffered FIFO, a status register and a halt register.
// PARAMETERS
//  ADDR_BITS      12  RAM byte-address width; RAM size is 2**ADDR_BITS bytes. Higher address bits are ignored for RAM (aliases).
//  PC_BITS        12  inst_addr width; must be <= ADDR_BITS.
//  RD_LATENCY     1   data-read latency, rreq to rack, in cycles; legal range 1..4.
//  N_CHAN         2   console channels, 1..8.
//  CONSOLE_DEPTH  16  console FIFO entries; power of 2, >= 2.
// PORTS
//  clk         in   1          clock, rising edge
//  reset       in   1          asynchronous reset, active-high
//  inst_addr   in   PC_BITS    instruction byte address; bit 0 ignored
//  inst        out  16         registered instruction halfword
//  inst_regce  in   1          load enable for inst
//  addr        in   32         data byte address; bits [1:0] ignored
//  wdata       in   32         store data
//  wmask       in   4          byte write enables; 0 means no store
//  rreq        in   1          load request
//  rdata       out  32         load data, valid while rack=1
//  rack        out  1          load acknowledge, one cycle per rreq
//  con_valid   out  1          console FIFO head valid
//  con_chan    out  3          head channel number
//  con_data    out  32         head data word
//  con_ready   in   1          consumer accept; pop when con_valid & con_ready
//  overflow    out  1          sticky: a console word was dropped
//  halt        out  1          sticky: program halted
//  halt_code   out  32         wdata of the halting store
// BEHAVIOUR
//  Reset: inst, rdata, con_data, con_chan, halt_code = 0; rack, con_valid, overflow, halt = 0.
//  Reset also empties the FIFO and flushes the read pipeline; in-flight racks are dropped. RAM contents are retained.
//  Fetch: each cycle a latch register loads RAM[inst_addr] (halfword); when inst_regce=1, inst <= latch.
//    inst therefore lags inst_addr by 2 cycles.
//  Load: rreq is accepted every cycle (fully pipelined). rack=1 and rdata are presented exactly RD_LATENCY cycles later.
//  Store: RAM bytes written under wmask; no acknowledge. Read and write of the same word in one cycle returns OLD data, on both ports.
//  MMIO window: addr[31:8]=24'hFFFFFF; it never touches RAM. Stores to it act only when wmask=4'hF; partial stores are ignored.
//    FFFFFF00+4c (c<N_CHAN)  W  push {c,wdata} to console
//    FFFFFFF8                W  alias of channel 0
//    FFFFFFF4                R  {overflow, 15'b0, level[15:0]}; W (any wdata) clears overflow
//    FFFFFFF0                R  cycle counter (see CONFIGURATION)
//    FFFFFFFC                W  halt<=1, halt_code<=wdata
//    Unmapped MMIO: reads return 0, writes are ignored.
//  FIFO: push and pop can occur in the same cycle. When full, push with pop succeeds and level is unchanged.
//    When full, push without pop drops the word and sets overflow; the drop is not raised as an error.
//  con_* hold stable while con_valid=1 and con_ready=0.
//  Halt: after halt=1, all further stores (RAM and MMIO) are ignored. Loads, fetches and FIFO drain continue.
//    halt clears only on reset.
//  Overflow-clear and a dropping push in the same cycle: overflow ends at 1.
// CONFIGURATION
//  MINIMAX_SYSMEM_CYCLE_COUNTER_EN defined: 32-bit counter, 0 at reset, +1 per cycle, wraps at 2**32.
//    Readable at FFFFFFF0.
//  Not defined: no counter logic is built; FFFFFFF0 reads 0.
// TESTING
//  RD_LATENCY=3, RAM[0x40]=0xDEADBEEF; rreq at cycle t with addr=0x40 -> rack=1, rdata=DEADBEEF at t+3 only.
//  Back-to-back rreq to 0x40 and 0x44 -> two consecutive rack cycles, in order, no bubble.
//  Store wmask=0011, wdata=0x12345678 to 0x40 -> next load returns DEAD5678.
//    inst_addr=0x40 later yields inst=5678; a load in the store cycle returns DEADBEEF.
//  con_ready=0; 17 full-word stores to FFFFFF04 with CONSOLE_DEPTH=16 -> level=16, overflow=1, status reads 0x80000010.
//    Raising con_ready drains 16 words, chan=1, in order. A store to FFFFFFF4 then clears overflow.
//  Store 0x2A to FFFFFFFC -> halt=1, halt_code=0x2A; a later RAM store is ignored.
//    Asserting reset mid-burst clears halt, rack and con_valid asynchronously.

Source files
------------

// File: rtl/minimax_sysmem.sv
// Shared instruction/data RAM plus top-of-memory MMIO (console FIFO, status, halt) for the minimax core.
// The cycle counter at FFFFFFF0 is built only when MINIMAX_SYSMEM_CYCLE_COUNTER_EN is defined.
module minimax_sysmem #(
  parameter int ADDR_BITS     = 12,
  parameter int PC_BITS       = 12,
  parameter int RD_LATENCY    = 1,
  parameter int N_CHAN        = 2,
  parameter int CONSOLE_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_BITS-1:0]   inst_addr,
  output logic [15:0]          inst,
  input  logic                 inst_regce,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wmask,
  input  logic                 rreq,
  output logic [31:0]          rdata,
  output logic                 rack,
  output logic                 con_valid,
  output logic [2:0]           con_chan,
  output logic [31:0]          con_data,
  input  logic                 con_ready,
  output logic                 overflow,
  output logic                 halt,
  output logic [31:0]          halt_code
);
  localparam int WORDS = 2 ** (ADDR_BITS - 2);
  localparam int PTR_W = $clog2(CONSOLE_DEPTH);
  localparam logic [7:0] OFF_COUNTER = 8'hF0;
  localparam logic [7:0] OFF_STATUS  = 8'hF4;
  localparam logic [7:0] OFF_CON0    = 8'hF8;
  localparam logic [7:0] OFF_HALT    = 8'hFC;

  logic [31:0]          ram_q [WORDS];
  logic [15:0]          latch_q, inst_q;
  logic [ADDR_BITS-1:0] inst_byte;
  logic [ADDR_BITS-3:0] inst_idx, data_idx;

  logic        mmio_sel, chan_hit, store_en, ram_we, mmio_we;
  logic [7:0]  mmio_off;
  logic        push_req, push_ok, drop, pop, full, ovf_clr, halt_set;
  logic [2:0]  push_chan;
  logic [31:0] mmio_rdata, cycle_val;

  logic [34:0]      fifo_q [CONSOLE_DEPTH];
  logic [34:0]      head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d, halt_q, halt_d;
  logic [31:0]      halt_code_q, halt_code_d;

  logic [RD_LATENCY-1:0] vld_q;
  logic [31:0]           pipe_q [RD_LATENCY];

  // Bits that carry no information: byte lanes within a word and the halfword LSB.
  logic unused_ok;
  assign unused_ok = ^{addr[1:0], inst_byte[0]};

  assign inst_byte = ADDR_BITS'(inst_addr);
  assign inst_idx  = inst_byte[ADDR_BITS-1:2];
  assign data_idx  = addr[ADDR_BITS-1:2];

  assign mmio_sel  = (addr[31:8] == 24'hFFFFFF);
  assign mmio_off  = {addr[7:2], 2'b00};
  assign chan_hit  = int'(addr[7:2]) < N_CHAN;
  assign store_en  = (wmask != 4'h0) && !halt_q;
  assign ram_we    = store_en && !mmio_sel;
  assign mmio_we   = store_en && mmio_sel && (wmask == 4'hF);
  assign push_req  = mmio_we && (chan_hit || mmio_off == OFF_CON0);
  assign push_chan = (mmio_off == OFF_CON0) ? 3'd0 : addr[4:2];
  assign ovf_clr   = mmio_we && (mmio_off == OFF_STATUS);
  assign halt_set  = mmio_we && (mmio_off == OFF_HALT);

  assign full    = (count_q == (PTR_W+1)'(CONSOLE_DEPTH));
  assign pop     = con_valid && con_ready;
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

`ifdef MINIMAX_SYSMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 32'd1;
  end
  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    mmio_rdata = '0;
    case (mmio_off)
      OFF_STATUS:  mmio_rdata = {ovf_q, 15'b0, 16'(count_q)};
      OFF_COUNTER: mmio_rdata = cycle_val;
      default:     mmio_rdata = '0;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    halt_d      = halt_q || halt_set;
    halt_code_d = halt_set ? wdata : halt_code_q;
    // A dropped word wins over a same-cycle clear.
    ovf_d       = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: RAM and FIFO storage have no reset so they map onto memory macros; RAM survives reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) ram_q[data_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    latch_q <= inst_byte[1] ? ram_q[inst_idx][31:16] : ram_q[inst_idx][15:0];
    if (push_ok) fifo_q[wr_ptr_q] <= {push_chan, wdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q      <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      vld_q       <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (inst_regce) inst_q <= latch_q;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      vld_q[0]    <= rreq;
      pipe_q[0]   <= mmio_sel ? mmio_rdata : ram_q[data_idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign head      = fifo_q[rd_ptr_q];
  assign con_valid = (count_q != '0);
  assign con_chan  = con_valid ? head[34:32] : 3'd0;
  assign con_data  = con_valid ? head[31:0] : 32'd0;
  assign inst      = inst_q;
  assign rack      = vld_q[RD_LATENCY-1];
  assign rdata     = pipe_q[RD_LATENCY-1];
  assign overflow  = ovf_q;
  assign halt      = halt_q;
  assign halt_code = halt_code_q;
endmodule

// File: tb/tb_minimax_sysmem.sv
// Randomised scoreboard bench for minimax_sysmem: a byte-array/queue model predicts loads, console words,
// fetches and sticky flags; a negedge monitor compares whatever the DUT presents.
module tb_minimax_sysmem;
  localparam int LAT   = 3;
  localparam int DEPTH = 16;
  localparam int NCH   = 2;

  logic        clk = 1'b0, reset = 1'b0;
  logic [11:0] inst_addr = '0;
  logic        inst_regce = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wmask = '0;
  logic        rreq = 1'b0, con_ready = 1'b0;
  logic [15:0] inst;
  logic [31:0] rdata, con_data, halt_code;
  logic        rack, con_valid, overflow, halt;
  logic [2:0]  con_chan;

  minimax_sysmem #(.ADDR_BITS(12), .PC_BITS(12), .RD_LATENCY(LAT), .N_CHAN(NCH), .CONSOLE_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .inst_addr(inst_addr), .inst(inst), .inst_regce(inst_regce),
    .addr(addr), .wdata(wdata), .wmask(wmask), .rreq(rreq), .rdata(rdata), .rack(rack),
    .con_valid(con_valid), .con_chan(con_chan), .con_data(con_data), .con_ready(con_ready),
    .overflow(overflow), .halt(halt), .halt_code(halt_code));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; bit chk; int due; } load_t;
  load_t       ld_q[$];
  logic [34:0] con_q[$];
  logic [7:0]  m_mem [4096];
  int          m_lvl;
  bit          m_ovf, m_halt, m_inst_ok, m_latch_ok;
  logic [31:0] m_hcode;
  logic [15:0] m_inst, m_latch;
  int          cyc = 0;
  bit          mon_on = 1'b0;
  int          n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ld_q.delete();
    con_q.delete();
    m_lvl = 0; m_ovf = 0; m_halt = 0; m_hcode = '0;
    m_inst = '0; m_inst_ok = 1; m_latch_ok = 0;
  endtask

  // One clock: drive the data port, then advance the model by the effect of that edge.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm, input logic rq);
    logic [31:0] rd_exp;
    bit          rd_chk, mm, pop_now, push, drop, clr;
    logic [7:0]  off;
    logic [2:0]  ch;
    int          b, ib;
    addr = a; wdata = wd; wmask = wm; rreq = rq;
    @(posedge clk);
    cyc++;
    mm  = (a[31:8] == 24'hFFFFFF);
    off = {a[7:2], 2'b00};
    b   = int'({a[11:2], 2'b00});
    rd_exp = '0; rd_chk = 1;
    if (!mm) rd_exp = {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
    else if (off == 8'hF4) rd_exp = {m_ovf, 15'b0, 16'(m_lvl)};
`ifdef MINIMAX_SYSMEM_CYCLE_COUNTER_EN
    else if (off == 8'hF0) rd_chk = 0;
`endif
    if (rq) ld_q.push_back('{rd_exp, rd_chk, cyc + LAT - 1});
    if (inst_regce) begin m_inst = m_latch; m_inst_ok = m_latch_ok; end
    ib = int'({inst_addr[11:1], 1'b0});
    m_latch = {m_mem[ib+1], m_mem[ib]}; m_latch_ok = 1;
    pop_now = (m_lvl > 0) && con_ready;
    push = 0; drop = 0; clr = 0; ch = '0;
    if (wm != 4'h0 && !m_halt) begin
      if (!mm) begin
        for (int i = 0; i < 4; i++) if (wm[i]) m_mem[b+i] = wd[8*i +: 8];
      end else if (wm == 4'hF) begin
        if (int'(off) < 4*NCH) begin push = 1; ch = off[4:2]; end
        else if (off == 8'hF8) begin push = 1; ch = 3'd0; end
        else if (off == 8'hF4) clr = 1;
        else if (off == 8'hFC) begin m_halt = 1; m_hcode = wd; end
      end
    end
    if (push) begin
      if (m_lvl < DEPTH || pop_now) begin con_q.push_back({ch, wd}); m_lvl++; end
      else drop = 1;
    end
    if (pop_now) m_lvl--;
    if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
    #1;
    wmask = '0; rreq = 1'b0;
  endtask

  always @(negedge clk) begin
    load_t       e;
    logic [34:0] c;
    if (mon_on) begin
      if (ld_q.size() > 0 && ld_q[0].due == cyc) begin
        e = ld_q.pop_front();
        check("rack", 32'(rack), 32'd1);
        if (e.chk) check("rdata", rdata, e.data);
      end else check("rack_idle", 32'(rack), 32'd0);
      if (con_valid && con_ready) begin
        if (con_q.size() == 0) check("con_spurious", 32'd1, 32'd0);
        else begin
          c = con_q.pop_front();
          check("con_chan", 32'(con_chan), 32'(c[34:32]));
          check("con_data", con_data, c[31:0]);
        end
      end
      check("con_valid", 32'(con_valid), 32'(m_lvl > 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("halt", 32'(halt), 32'(m_halt));
      check("halt_code", halt_code, m_hcode);
      if (m_inst_ok) check("inst", 32'(inst), 32'(m_inst));
    end
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  offs [7];
    int          r;
    offs = '{8'h00, 8'h04, 8'h08, 8'hF0, 8'hF4, 8'hF8, 8'h80};
    for (int i = 0; i < 4096; i++) m_mem[i] = '0;
    model_reset();
    #1 reset = 1'b1;
    #10;
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rack", 32'(rack), 32'd0);
    check("rst_con_valid", 32'(con_valid), 32'd0);
    check("rst_con_chan", 32'(con_chan), 32'd0);
    check("rst_con_data", con_data, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_halt_code", halt_code, 32'd0);
    @(negedge clk) reset = 1'b0;
    mon_on = 1'b1;

    for (int w = 0; w < 1024; w++) step(32'(w*4), $urandom, 4'hF, 1'b0);
    step(32'h40, 32'hDEADBEEF, 4'hF, 1'b0);
    step(32'h0, 32'h0, 4'h0, 1'b0);
    inst_regce = 1'b1;

    // Latency, back-to-back loads, partial store with same-cycle load returning old data.
    step(32'h40, 32'h0, 4'h0, 1'b1);
    step(32'h0, 32'h0, 4'h0, 1'b0);
    step(32'h40, 32'h0, 4'h0, 1'b1);
    step(32'h44, 32'h0, 4'h0, 1'b1);
    step(32'h40, 32'h12345678, 4'b0011, 1'b1);
    inst_addr = 12'h040;
    step(32'h40, 32'h0, 4'h0, 1'b1);
    repeat (4) step(32'h0, 32'h0, 4'h0, 1'b0);
    check("inst_5678", 32'(inst), 32'h5678);

    // Fill the console beyond depth, read status, push into a full FIFO while popping, then drain.
    con_ready = 1'b0;
    for (int i = 0; i < 17; i++) step(32'hFFFFFF04, 32'h100 + 32'(i), 4'hF, 1'b0);
    step(32'hFFFFFFF4, 32'h0, 4'h0, 1'b1);
    check("overflow_set", 32'(overflow), 32'd1);
    con_ready = 1'b1;
    step(32'hFFFFFF04, 32'h200, 4'hF, 1'b0);
    repeat (20) step(32'h0, 32'h0, 4'h0, 1'b0);
    step(32'hFFFFFFF4, 32'h0, 4'hF, 1'b0);
    check("overflow_clr", 32'(overflow), 32'd0);
    step(32'hFFFFFF00, 32'h300, 4'b0111, 1'b0);
    step(32'hFFFFFF08, 32'h301, 4'hF, 1'b0);
    step(32'hFFFFFF80, 32'h302, 4'hF, 1'b1);
    step(32'hFFFFFFF8, 32'h303, 4'hF, 1'b0);
    step(32'hFFFFFFF0, 32'h0, 4'h0, 1'b1);
    repeat (4) step(32'h0, 32'h0, 4'h0, 1'b0);

    // Randomised traffic over RAM (with aliasing) and the MMIO window, halt register excluded.
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        a = $urandom;
        if (a[31:8] == 24'hFFFFFF) a[31] = 1'b0;
      end else a = {24'hFFFFFF, offs[$urandom_range(0, 6)]};
      con_ready  = 1'($urandom_range(0, 1));
      inst_addr  = 12'($urandom);
      inst_regce = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      step(a, $urandom, (r < 4) ? 4'h0 : (r < 7) ? 4'hF : 4'($urandom),
           1'($urandom_range(0, 1)));
    end
    inst_regce = 1'b1;
    con_ready  = 1'b1;
    repeat (20) step(32'h0, 32'h0, 4'h0, 1'b0);

    // Halt with words queued, then loads in flight when reset is asserted asynchronously.
    con_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(32'hFFFFFF00, 32'h400 + 32'(i), 4'hF, 1'b0);
    step(32'hFFFFFFFC, 32'h2A, 4'hF, 1'b0);
    check("halt_set", 32'(halt), 32'd1);
    check("halt_code_2a", halt_code, 32'h2A);
    step(32'h40, 32'hFFFFFFFF, 4'hF, 1'b0);
    step(32'hFFFFFF04, 32'h500, 4'hF, 1'b0);
    step(32'h40, 32'h0, 4'h0, 1'b1);
    step(32'h44, 32'h0, 4'h0, 1'b1);
    step(32'h48, 32'h0, 4'h0, 1'b1);
    #2;
    mon_on = 1'b0;
    reset  = 1'b1;
    #1;
    check("async_halt", 32'(halt), 32'd0);
    check("async_rack", 32'(rack), 32'd0);
    check("async_con_valid", 32'(con_valid), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    mon_on = 1'b1;

    step(32'h40, 32'h0, 4'h0, 1'b1);
    step(32'h40, 32'hCAFEF00D, 4'hF, 1'b0);
    step(32'h40, 32'h0, 4'h0, 1'b1);
    con_ready = 1'b1;
    repeat (8) step(32'h0, 32'h0, 4'h0, 1'b0);
    check("loads_drained", 32'(ld_q.size()), 32'd0);
    check("console_drained", 32'(con_q.size()), 32'd0);
    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
